// File: rtl/lsu_bus_master.sv
// Data-memory bus initiator: one outstanding load or store over split read/write channels.
// Store lanes and load extension are resolved here so the pipeline only sees aligned data.
module lsu_bus_master #(
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_type,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bresp,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WRITE, S_WRESP, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  req_off;
    logic [1:0]  req_size;       // 0 byte, 1 half, 2 word, 3 illegal type
    logic        req_misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_shifted;
    logic [31:0] ld_ext;

    always_comb begin
        req_off = req_addr[1:0];
        case (req_type)
            3'd0, 3'd3: req_size = 2'd0;
            3'd1, 3'd4: req_size = 2'd1;
            3'd2:       req_size = 2'd2;
            default:    req_size = 2'd3;
        endcase
        req_misaligned = ((req_size == 2'd1) && req_off[0]) ||
                         ((req_size == 2'd2) && (req_off != 2'd0));
        case (req_size)
            2'd0: begin
                st_strb = 4'b0001 << req_off;
                st_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                st_strb = 4'b0011 << req_off;
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    // Lanes above the top byte shift in as zero, so a half at offset 3 loads an empty upper half.
    always_comb begin
        ld_shifted = rdata >> {addr_q[1:0], 3'b000};
        case (type_q)
            3'd0:    ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'd1:    ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'd2:    ld_ext = ld_shifted;
            3'd3:    ld_ext = {24'h0, ld_shifted[7:0]};
            3'd4:    ld_ext = {16'h0, ld_shifted[15:0]};
            default: ld_ext = 32'h0;
        endcase
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        type_d     = type_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    type_d  = req_type;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (req_wen) begin
                        wdata_d = st_data;
                        wstrb_d = st_strb;
                    end
                    if ((req_size == 2'd3) || (MISALIGN_CHK && req_misaligned)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (req_wen) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    rdata_d = ld_ext;
                    err_d   = rresp;
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                // Address and data channels retire independently, in any order.
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WRESP;
                end
            end
            S_WRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    err_d   = bresp;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'h0;
            type_q    <= 3'd0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign araddr     = {addr_q[31:2], 2'b00};
    assign awaddr     = {addr_q[31:2], 2'b00};
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
